// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared op codes, port ids and FSM state encoding for the memory arbiter
package mem_arbiter_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select between fetch and data ports; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  // A lone requester always wins; a tie is resolved by priority or by rotation.
  // With no request the winner is a don't-care, so it simply repeats last_grant.
  always_comb begin
    any_req = if_req | d_req;
    winner  = last_grant;
    if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
`else
      winner = PORT_D;
`endif
    end else if (d_req) begin
      winner = PORT_D;
    end else if (if_req) begin
      winner = PORT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - grant/ack sequencer sharing one 16-bit memory between fetch and data ports (tie policy via MEM_ARB_ROUND_ROBIN_EN in mem_arb_pick)
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_op,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        mem_op,
  output logic [15:0] mem_addr,
  inout  wire  [15:0] mem_data
);

  state_t      state;
  state_t      state_nx;
  logic        owner;
  logic        last_grant;
  logic        lat_op;
  logic [15:0] lat_wdata;
  logic        any_req;
  logic        winner;
  logic        drive_write;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: every access is exactly one GRANT followed by one ACK; ACK can chain straight into GRANT.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE,
      ST_ACK:   state_nx = any_req ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_nx = ST_ACK;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs: acks follow the owner in ACK; a write is only driven in GRANT and never while reset is high.
  always_comb begin
    if_ack      = (state == ST_ACK) && (owner == PORT_IF);
    d_ack       = (state == ST_ACK) && (owner == PORT_D);
    drive_write = !reset && (state == ST_GRANT) && (owner == PORT_D) && (lat_op == OP_WRITE);
    mem_op      = drive_write ? OP_WRITE : OP_READ;
  end

  assign mem_data = drive_write ? lat_wdata : 16'bz;

  // Request latch at grant and read-data capture at the end of GRANT.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= PORT_IF;
      last_grant <= PORT_IF;
      mem_addr   <= 16'h0000;
      lat_op     <= OP_READ;
      lat_wdata  <= 16'h0000;
      if_rdata   <= 16'h0000;
      d_rdata    <= 16'h0000;
    end else begin
      if (state == ST_GRANT) begin
        if (owner == PORT_IF) begin
          if_rdata <= mem_data;
        end else if (lat_op == OP_READ) begin
          d_rdata <= mem_data;
        end
      end
      if (state_nx == ST_GRANT) begin
        owner      <= winner;
        last_grant <= winner;
        mem_addr   <= (winner == PORT_D) ? d_addr : if_addr;
        lat_op     <= (winner == PORT_D) ? d_op : OP_READ;
        lat_wdata  <= d_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with byte memory, transaction model and directed tests
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic        d_req = 1'b0;
  logic        d_op = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  wire         if_ack;
  wire  [15:0] if_rdata;
  wire         d_ack;
  wire  [15:0] d_rdata;
  wire         mem_op;
  wire  [15:0] mem_addr;
  wire  [15:0] mem_data;

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_op     (d_op),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_op   (mem_op),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  // Byte-wide little-endian memory; word at a is {mem[a+1], mem[a]} with 16-bit wrap.
  bit [7:0]    hmem [0:65535];
  bit          preloaded = 1'b0;
  wire  [15:0] addr_hi = mem_addr + 16'd1;

  assign mem_data = (mem_op == OP_READ) ? {hmem[addr_hi], hmem[mem_addr]} : 16'hzzzz;

  always @(posedge clk) begin
    if (!preloaded) begin
      hmem[16'h0100] <= 8'h34;
      hmem[16'h0101] <= 8'h12;
      hmem[16'h0102] <= 8'hCD;
      hmem[16'h0103] <= 8'hAB;
      hmem[16'h0300] <= 8'h5A;
      hmem[16'h0301] <= 8'hC3;
      preloaded <= 1'b1;
    end else if (mem_op == OP_WRITE) begin
      hmem[mem_addr] <= mem_data[7:0];
      hmem[addr_hi]  <= mem_data[15:8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Transaction model: one pending access, a phase counter and a reference byte memory.
  typedef struct packed {
    logic        port;
    logic        op;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  bit [7:0]    ref_mem [0:65535];
  int          phase = 0;
  acc_t        cur = '0;
  logic        m_last = PORT_IF;
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] exp_if_rdata = 16'h0000;
  logic [15:0] exp_d_rdata = 16'h0000;
  bit          model_valid = 1'b0;
  int          if_ack_seen = 0;
  int          d_ack_seen = 0;
  int          cyc = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  always @(posedge clk) begin
    logic        win;
    logic [15:0] a1;
    cyc++;
    if (!preloaded) begin
      ref_mem[16'h0100] = 8'h34;
      ref_mem[16'h0101] = 8'h12;
      ref_mem[16'h0102] = 8'hCD;
      ref_mem[16'h0103] = 8'hAB;
      ref_mem[16'h0300] = 8'h5A;
      ref_mem[16'h0301] = 8'hC3;
    end
    if (reset) begin
      phase        = 0;
      cur          = '0;
      m_last       = PORT_IF;
      m_addr       = 16'h0000;
      exp_if_rdata = 16'h0000;
      exp_d_rdata  = 16'h0000;
      model_valid  = 1'b1;
    end else if (phase == 1) begin
      a1 = cur.addr + 16'd1;
      if (cur.port == PORT_D && cur.op == OP_WRITE) begin
        ref_mem[cur.addr] = cur.wdata[7:0];
        ref_mem[a1]       = cur.wdata[15:8];
      end else if (cur.port == PORT_IF) begin
        exp_if_rdata = {ref_mem[a1], ref_mem[cur.addr]};
      end else begin
        exp_d_rdata = {ref_mem[a1], ref_mem[cur.addr]};
      end
      phase = 2;
    end else if (if_req || d_req) begin
      if (if_req && d_req) win = RR_MODE ? ~m_last : PORT_D;
      else win = d_req ? PORT_D : PORT_IF;
      if (win == PORT_D) cur = '{PORT_D, d_op, d_addr, d_wdata};
      else cur = '{PORT_IF, OP_READ, if_addr, 16'h0000};
      m_last = win;
      m_addr = cur.addr;
      phase  = 1;
    end else begin
      phase = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit wr_exp;
    if (model_valid) begin
      wr_exp = !reset && phase == 1 && cur.port == PORT_D && cur.op == OP_WRITE;
      check("if_ack", if_ack, (phase == 2) && (cur.port == PORT_IF));
      check("d_ack", d_ack, (phase == 2) && (cur.port == PORT_D));
      check("mem_addr", mem_addr, m_addr);
      check("mem_op", mem_op, wr_exp ? OP_WRITE : OP_READ);
      check("if_rdata", if_rdata, exp_if_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      if (wr_exp) check("mem_data", mem_data, cur.wdata);
      if (if_ack) if_ack_seen++;
      if (d_ack) d_ack_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic access(input logic port, input logic op, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    if (port == PORT_D) begin
      d_req = 1'b1; d_op = op; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      lat++;
      if ((port == PORT_D) ? d_ack : if_ack) got = 1'b1;
    end
    if (port == PORT_D) d_req = 1'b0;
    else if_req = 1'b0;
    check("access_ack_seen", got, 1);
    tick();
  endtask

  initial begin
    int   lat;
    int   n;
    bit   got;
    logic seq [0:3];
    int   ack_at [0:3];
    logic exp_seq [0:3];

    do_reset();

    // Fetch read of 0x0100.
    d_ack_seen = 0;
    access(PORT_IF, OP_READ, 16'h0100, 16'h0000, lat);
    check("t1_latency", lat, 3);
    check("t1_if_rdata", if_rdata, 16'h1234);
    check("t1_no_d_ack", d_ack_seen, 0);

    // Data write then read back.
    access(PORT_D, OP_WRITE, 16'h0200, 16'hBEEF, lat);
    check("t2_mem_lo", hmem[16'h0200], 8'hEF);
    check("t2_mem_hi", hmem[16'h0201], 8'hBE);
    access(PORT_D, OP_READ, 16'h0200, 16'h0000, lat);
    check("t2_d_rdata", d_rdata, 16'hBEEF);
    check("t2_if_rdata_kept", if_rdata, 16'h1234);

    // Both ports held high through four grants.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_op = OP_READ; d_addr = 16'h0200; d_wdata = 16'h0000;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        seq[n] = d_ack ? PORT_D : PORT_IF;
        ack_at[n] = cyc;
        n++;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    tick();
    check("t3_grants", n, 4);
    exp_seq[0] = PORT_D;
    exp_seq[1] = RR_MODE ? PORT_IF : PORT_D;
    exp_seq[2] = PORT_D;
    exp_seq[3] = RR_MODE ? PORT_IF : PORT_D;
    for (int k = 0; k < 4; k++) check($sformatf("t3_owner%0d", k), seq[k], exp_seq[k]);
    for (int k = 1; k < 4; k++) check($sformatf("t3_spacing%0d", k), ack_at[k] - ack_at[k-1], 2);

    // Reset asserted during the GRANT cycle of a data write.
    d_req = 1'b1; d_op = OP_WRITE; d_addr = 16'h0300; d_wdata = 16'hAAAA;
    tick();
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    check("t4_mem_op_forced", mem_op, OP_READ);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t4_no_d_ack", d_ack, 1'b0);
    check("t4_mem_addr", mem_addr, 16'h0000);
    check("t4_if_rdata", if_rdata, 16'h0000);
    check("t4_d_rdata", d_rdata, 16'h0000);
    check("t4_mem_lo", hmem[16'h0300], 8'h5A);
    check("t4_mem_hi", hmem[16'h0301], 8'hC3);
    tick();

    // Write at 0xFFFF wraps its high byte to 0x0000.
    access(PORT_D, OP_WRITE, 16'hFFFF, 16'h5678, lat);
    check("t5_mem_ffff", hmem[16'hFFFF], 8'h78);
    check("t5_mem_0000", hmem[16'h0000], 8'h56);
    access(PORT_IF, OP_READ, 16'hFFFF, 16'h0000, lat);
    check("t5_if_rdata", if_rdata, 16'h5678);

    // Fetch request kept high across its ack with a new address.
    if_req = 1'b1; if_addr = 16'h0100;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (if_ack) got = 1'b1;
    end
    check("t6_first_ack", got, 1);
    check("t6_first_rdata", if_rdata, 16'h1234);
    if_addr = 16'h0102;
    @(negedge clk);
    check("t6_regrant_addr", mem_addr, 16'h0102);
    check("t6_regrant_no_ack", if_ack, 1'b0);
    @(negedge clk);
    check("t6_second_ack", if_ack, 1'b1);
    check("t6_second_rdata", if_rdata, 16'hABCD);
    if_req = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single-ported 16-bit memory between the instruction-fetch port and the load/store data port. It sequences every access as one grant cycle followed by one acknowledge cycle. It drives the memory's `op`/`addr`/`data` bus, returns read words to the winning requester, and guarantees that no write reaches memory while reset is asserted. It sits between the fetch and execute stages and the memory model.

## Interface
- No parameters. Address width and data width are both fixed at 16.
- `clk`  in  1  system clock; memory writes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held high with `if_addr` stable until `if_ack`.
- `if_addr`  in  16  fetch byte address.
- `if_ack`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid.
- `if_rdata`  out  16  registered fetch word.
- `d_req`  in  1  data request; held with `d_op`/`d_addr`/`d_wdata` stable until `d_ack`.
- `d_op`  in  1  `READ`/`WRITE` (shared op encoding).
- `d_addr`  in  16  data byte address.
- `d_wdata`  in  16  write word.
- `d_ack`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  16  registered data-read word; updated only on reads.
- `mem_op`  out  1  memory op.
- `mem_addr`  out  16  memory byte address.
- `mem_data`  inout  16  memory data bus; driven only in the GRANT cycle of a data write, otherwise Z.

## Operation
- FSM states: IDLE, GRANT, ACK. Registered `owner` (IF/D) and `last_grant` (IF/D).
- IDLE or ACK, at the clock edge:
  - If any request is high, select a winner, then load `owner`, `mem_addr`, and the latched op/wdata, and go to GRANT.
  - Otherwise go to IDLE.
- Arbitration from ACK sees the current `req` levels. A requester that wants only one access drops `req` during its ack cycle; a `req` still high at that edge is a new request.
- GRANT:
  - `mem_addr` is the winner's address.
  - `mem_op` = `WRITE` only if owner = D and the latched op = `WRITE`; otherwise `READ`.
  - Read data is combinational from memory and is captured at the edge into the owner's `*_rdata`.
  - A write commits at that same edge.
  - Next state is ACK, with the owner's ack asserted.
- ACK: the owner's ack is high for exactly this cycle. The loser's ack stays 0.
- Address arithmetic is not done here. Addresses pass through unmodified; the memory handles `addr+1` wrap (0xFFFF pairs with 0x0000). Odd addresses are legal.
- Write data, op and address are latched at grant. Requester changes during GRANT are ignored.
- `mem_op` is forced to `READ` and `mem_data` is released whenever `reset` is high, independent of state. A write in flight at a reset edge is dropped.
- `last_grant` updates to the winner at each grant.

## Timing
- Reset values:
  - state IDLE, `owner` IF, `last_grant` IF
  - `if_ack` 0, `d_ack` 0
  - `if_rdata` 0x0000, `d_rdata` 0x0000
  - `mem_addr` 0x0000, `mem_op` `READ`, `mem_data` Z
- Latency: request sampled at edge N → GRANT in cycle N+1 → ack in cycle N+2.
- Throughput with continuous requests: one access every 2 cycles.
- Reset during GRANT: no write, no ack, IDLE on the next cycle. Reset during ACK: ack drops the next cycle, and the captured rdata is reset to 0.
- Simultaneous `if_req` and `d_req` in IDLE/ACK: resolved per the Configuration section.
- Requests that arrive during GRANT are not seen until the edge ending ACK.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, the port other than `last_grant` wins.
  - `last_grant` resets to IF, so the first tie goes to D.
  - Neither port waits more than one other access.
- Undefined: fixed priority. D always beats IF, and IF can starve under continuous `d_req`. `last_grant` is still maintained but does not affect selection.

## Structure
- The shared CPU package holds `READ`/`WRITE` op constants, the FSM state encoding (IDLE/GRANT/ACK) and the port ID constants IF/D.
- One sub-module, `mem_arb_pick`: combinational winner select from `if_req`, `d_req`, `last_grant`. The macro is confined to it.
- The FSM, latches and bus drive stay in `mem_arbiter`.

## Test plan
- Preload mem[0x0100]=0x34, mem[0x0101]=0x12. Pulse-hold `if_req`, `if_addr`=0x0100. Expect `if_ack` 2 cycles after the sampling edge, `if_rdata`=0x1234, `d_ack` never high.
- D write 0x0200 ← 0xBEEF, then D read 0x0200. Expect mem[0x0200]=0xEF, mem[0x0201]=0xBE, `d_rdata`=0xBEEF, and `if_rdata` unchanged.
- Hold `if_req` and `d_req` high through 4 grants:
  - Without the macro: D, D, D, D, and `if_ack` never asserts.
  - With the macro: D, IF, D, IF, with `mem_addr` alternating accordingly.
- Assert `reset` in the GRANT cycle of D write 0x0300 ← 0xAAAA. Expect `mem_op`=`READ` in that cycle, mem[0x0300] unchanged, no `d_ack`, and IDLE plus all reset values next cycle.
- D write 0xFFFF ← 0x5678. Expect mem[0xFFFF]=0x78 and mem[0x0000]=0x56. A subsequent IF read of 0xFFFF returns 0x5678.
- Keep `if_req` high across its ack with `if_addr` changed to 0x0102 (preload mem[0x0102]=0xCD, mem[0x0103]=0xAB) in the ack cycle. Expect a second grant with no IDLE cycle in between, and `if_rdata`=0xABCD on the next ack.
